// File: rtl/mysystem_pio_key.sv
// Avalon-MM input PIO for the DE2 keys/switches: two-flop synchroniser, per-bit
// debounce, sticky edge capture with W1C clear, and a maskable level interrupt.
module mysystem_pio_key #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 1000,
   parameter int               EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] IN_RESET        = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_irqMask;
   logic [WIDTH-1:0] r_edgeCap;
   logic [CW-1:0]    r_cnt [WIDTH];

   logic             w_wr;
   logic [WIDTH-1:0] w_wrData;
   logic [WIDTH-1:0] w_accept;
   logic [WIDTH-1:0] w_event;
   logic [WIDTH-1:0] w_clr;

   assign w_wr     = chipselect & ~write_n;
   assign w_wrData = writedata[WIDTH-1:0];
   assign w_clr    = (w_wr && address == 2'd3) ? w_wrData : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= IN_RESET;
         r_sync2 <= IN_RESET;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
      end
   end

   always_comb begin
      w_event = '0;
      case (EDGE_TYPE)
         0:       w_event = w_accept & ~r_sync2;
         1:       w_event = w_accept & r_sync2;
         default: w_event = w_accept;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable <= IN_RESET;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A new edge event overrides a simultaneous write-1-to-clear on the same bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqMask <= '0;
         r_edgeCap <= '0;
      end else begin
         if (w_wr && address == 2'd2) begin
            r_irqMask <= w_wrData;
         end
         r_edgeCap <= (r_edgeCap & ~w_clr) | w_event;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = r_stable;
         2'd2:    readdata[WIDTH-1:0] = r_irqMask;
         2'd3:    readdata[WIDTH-1:0] = r_edgeCap;
         default: readdata = '0;
      endcase
   end

   assign irq = |(r_edgeCap & r_irqMask);

endmodule

// File: tb/tb_mysystem_pio_key.sv
// Bench for mysystem_pio_key: a falling-edge and an any-edge instance share one
// stimulus stream and are compared every cycle against a run-length key model.
module tb_mysystem_pio_key;

   localparam int DEB = 4;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  inPort;
   logic [31:0] readdata0;
   logic [31:0] readdata2;
   logic        irq0;
   logic        irq2;

   int checkCount;
   int passCount;

   // Model: raw samples delayed two clocks, then per-bit count of consecutive
   // disagreeing cycles; the DEB-th disagreement flips the accepted level.
   logic [3:0] delayLine [2];
   logic [3:0] mStable;
   int         mRun [4];
   logic [3:0] mMask;
   logic [3:0] mCap [2];

   mysystem_pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0), .IN_RESET(4'hF)) dutFall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(inPort),
      .readdata(readdata0), .irq(irq0));

   mysystem_pio_key #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2), .IN_RESET(4'hF)) dutAny (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(inPort),
      .readdata(readdata2), .irq(irq2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
      end
   endtask

   task automatic modelReset();
      delayLine[0] = 4'hF;
      delayLine[1] = 4'hF;
      mStable = 4'hF;
      for (int b = 0; b < 4; b++) mRun[b] = 0;
      mMask = 4'h0;
      mCap[0] = 4'h0;
      mCap[1] = 4'h0;
   endtask

   task automatic modelStep();
      logic [3:0] seen;
      logic [3:0] acc;
      logic [3:0] newStable;
      seen = delayLine[1];
      acc = 4'h0;
      for (int b = 0; b < 4; b++) begin
         if (seen[b] != mStable[b]) begin
            mRun[b] = mRun[b] + 1;
            if (mRun[b] == DEB) begin
               acc[b] = 1'b1;
               mRun[b] = 0;
            end
         end else begin
            mRun[b] = 0;
         end
      end
      newStable = mStable ^ acc;
      if (chipselect && !write_n) begin
         if (address == 2'd2) mMask = writedata[3:0];
         if (address == 2'd3) begin
            mCap[0] = mCap[0] & ~writedata[3:0];
            mCap[1] = mCap[1] & ~writedata[3:0];
         end
      end
      mCap[0] = mCap[0] | (acc & ~newStable);
      mCap[1] = mCap[1] | acc;
      mStable = newStable;
      delayLine[1] = delayLine[0];
      delayLine[0] = inPort;
   endtask

   function automatic logic [31:0] expRead(input int n);
      case (address)
         2'd0:    return {28'h0, mStable};
         2'd2:    return {28'h0, mMask};
         2'd3:    return {28'h0, mCap[n]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic checkAll();
      checkOutput("rdFall", readdata0, expRead(0));
      checkOutput("rdAny", readdata2, expRead(1));
      checkOutput("irqFall", {31'h0, irq0}, {31'h0, |(mCap[0] & mMask)});
      checkOutput("irqAny", {31'h0, irq2}, {31'h0, |(mCap[1] & mMask)});
   endtask

   // Drive one cycle of bus/key inputs, clock it, advance the model and compare.
   task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wn,
                                input logic [31:0] wd, input logic [3:0] inp);
      address = addr;
      chipselect = cs;
      write_n = wn;
      writedata = wd;
      inPort = inp;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n, input logic [1:0] addr, input logic [3:0] inp);
      for (int c = 0; c < n; c++) applyStimulus(addr, 1'b0, 1'b1, 32'h0, inp);
   endtask

   task automatic busWrite(input logic [1:0] addr, input logic [31:0] wd, input logic [3:0] inp);
      applyStimulus(addr, 1'b1, 1'b0, wd, inp);
   endtask

   // Asynchronous reset asserted between edges for one clock.
   task automatic pulseReset();
      reset_n = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(posedge clk);
      #1;
      checkAll();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [3:0] keys;
      checkCount = 0;
      passCount = 0;
      reset_n = 1'b0;
      address = 2'd0;
      chipselect = 1'b0;
      write_n = 1'b1;
      writedata = 32'h0;
      inPort = 4'hF;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      checkOutput("rstData", readdata0, 32'h0000000F);
      reset_n = 1'b1;

      busWrite(2'd0, 32'h5, 4'hF);
      idleCycles(1, 2'd2, 4'hF);
      idleCycles(1, 2'd3, 4'hF);
      idleCycles(1, 2'd0, 4'hF);
      checkOutput("dataWriteIgnored", readdata0, 32'h0000000F);

      // Key 0 pressed: visible on the sixth clock after it is driven.
      idleCycles(5, 2'd0, 4'hE);
      checkOutput("latencyBefore", readdata0, 32'h0000000F);
      idleCycles(1, 2'd0, 4'hE);
      checkOutput("latencyAfter", readdata0, 32'h0000000E);
      idleCycles(1, 2'd3, 4'hE);
      checkOutput("capFall", readdata0, 32'h1);

      // Short glitches on key 1 are rejected; the steady press is accepted.
      idleCycles(3, 2'd0, 4'hC);
      idleCycles(6, 2'd0, 4'hE);
      checkOutput("glitchData", readdata0, 32'h0000000E);
      idleCycles(2, 2'd3, 4'hC);
      idleCycles(2, 2'd3, 4'hE);
      idleCycles(8, 2'd3, 4'hC);
      checkOutput("capAfterPress", readdata0, 32'h3);

      checkOutput("irqMasked", {31'h0, irq0}, 32'h0);
      busWrite(2'd2, 32'h1, 4'hC);
      checkOutput("irqUnmasked", {31'h0, irq0}, 32'h1);
      busWrite(2'd3, 32'h2, 4'hC);
      idleCycles(1, 2'd3, 4'hC);
      checkOutput("capPartialClr", readdata0, 32'h1);
      busWrite(2'd3, 32'h1, 4'hC);
      checkOutput("irqCleared", {31'h0, irq0}, 32'h0);
      busWrite(2'd3, 32'hF, 4'hC);

      // Clear of key 2 lands on the very cycle its press is accepted.
      idleCycles(5, 2'd3, 4'h8);
      busWrite(2'd3, 32'h4, 4'h8);
      checkOutput("setWinsFall", readdata0, 32'h4);
      checkOutput("setWinsAny", readdata2, 32'h4);
      busWrite(2'd3, 32'h4, 4'h8);
      idleCycles(8, 2'd3, 4'hC);
      checkOutput("noRiseFall", readdata0, 32'h0);
      checkOutput("riseAny", readdata2, 32'h4);

      // Reset while key 3 is part-way through its debounce count.
      idleCycles(4, 2'd0, 4'h4);
      pulseReset();
      checkOutput("rstMidData", readdata0, 32'h0000000F);
      idleCycles(5, 2'd0, 4'h4);
      checkOutput("rstMidHold", readdata0, 32'h0000000F);
      idleCycles(1, 2'd0, 4'h4);
      checkOutput("rstMidAccept", readdata0, 32'h00000004);

      // Random keys, bus traffic and occasional resets.
      keys = 4'h4;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 399) == 0) begin
            pulseReset();
         end else begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), $urandom(), keys);
         end
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mysystem_pio_key.md
Name: mysystem_pio_key

Overview:
Avalon-MM slave input PIO. It is the read-side counterpart of the system's LED output PIO and serves the DE2 push-buttons/switches.
- Synchronises and debounces WIDTH external inputs.
- Captures selected edges per bit and raises a maskable level interrupt to the Nios II.
- Sits on the same Avalon-MM fabric with zero-wait-state reads.

Parameters:
WIDTH, 4, number of input bits (1..32)
DEBOUNCE_CYCLES, 1000, consecutive clk cycles a changed input must hold before it is accepted (>=1)
EDGE_TYPE, 0, capture polarity: 0 falling, 1 rising, 2 any edge
IN_RESET, 4'hF, reset value of synchroniser and debounced register (idle-high keys)

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset_n  input  1  asynchronous active-low reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
in_port  input  WIDTH  raw asynchronous external inputs
readdata  output  32  read data, combinational from address, 0 wait states
irq  output  1  level interrupt, active high

Behaviour:
- Reset (async, reset_n=0): sync1, sync2 and stable = IN_RESET; all debounce counters = 0; irq_mask = 0; edge_cap = 0; irq = 0. readdata follows the mux from reset state.
- Synchroniser: per bit, two flops, in_port -> sync1 -> sync2.
- Debounce, per bit i, with a counter of width clog2(DEBOUNCE_CYCLES)+1:
  - sync2[i]==stable[i]: cnt <= 0.
  - sync2[i]!=stable[i] and cnt==DEBOUNCE_CYCLES-1: stable[i] <= sync2[i]; cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A mismatch that ends before acceptance restarts the count from 0 on the next mismatch.
- Latency: a level change on in_port sampled at edge k is visible in stable after edge k+1+DEBOUNCE_CYCLES.
- Edge event: per bit, asserted in the cycle stable[i] is updated.
  - Qualified by EDGE_TYPE: 0 needs new value 0, 1 needs new value 1, 2 accepts either.
- Register map (reads):
  - addr 0: data = stable, zero-extended.
  - addr 1: reserved, reads 0.
  - addr 2: irq_mask, read/write.
  - addr 3: edge_cap.
  - Bits above WIDTH read 0.
  - Reads have no side effects; chipselect is not required for readdata.
- Writes (chipselect=1, write_n=0):
  - addr 2: irq_mask <= writedata[WIDTH-1:0].
  - addr 3: write-1-to-clear, edge_cap[i] cleared where writedata[i]=1.
  - addr 0/1: ignored.
- Simultaneous clear and new edge event on the same bit in the same cycle: set wins, bit stays 1.
- edge_cap bits are sticky until cleared or reset. Repeated edges while set have no further effect.
- irq = |(edge_cap & irq_mask), combinational from registers.
  - Asserts in the same cycle the edge_cap bit is visible.
  - Deasserts the cycle after a clearing write or a mask write of 0.
- Reset mid-debounce: the counter returns to 0 and stable to IN_RESET. No edge event is produced by reset itself.
- Bits are fully independent. Simultaneous acceptance on several bits sets all corresponding edge_cap bits in one cycle.

Test Plan:
1. Reset with in_port=4'hF -> readdata 0xF at addr 0, 0x0 at addr 2 and 3, irq=0. Write 0x5 to addr 0 -> addr 0 still reads 0xF.
2. DEBOUNCE_CYCLES=4, EDGE_TYPE=0: drive in_port[0] 1->0 before edge k, hold -> addr 0 reads 0xE only after edge k+5; edge_cap reads 0x1 from the same cycle.
3. DEBOUNCE_CYCLES=4: 3-cycle low glitch on in_port[1] -> data stays 0xF, edge_cap stays 0. Then a 2-cycle glitch followed by a steady low -> accepted exactly 4 mismatch cycles after the steady low reaches sync2.
4. irq_mask=0 with edge_cap=0x1 -> irq=0. Write 0x1 to addr 2 -> irq=1 next cycle. Write 0x2 to addr 3 -> edge_cap stays 0x1. Write 0x1 to addr 3 -> edge_cap=0, irq=0 next cycle.
5. Write 0x4 to addr 3 in the same cycle bit 2 is accepted falling -> edge_cap[2]=1 (set wins). Release bit 2 high with EDGE_TYPE=0 -> no new capture. Repeat with EDGE_TYPE=2 -> rising release is captured.
6. Assert reset_n=0 for 1 cycle while bit 3 counter is at 2 -> after release, counter restarts from 0, data=0xF, edge_cap=0, irq=0, and a held low input is accepted a full DEBOUNCE_CYCLES after sync2 mismatches.
